// File: rtl/lifo_drain_if.sv
// Output stream of the LIFO pop sequencer: valid/ready handshake plus a last marker.
// The sequencer drives the master side; the downstream consumer uses the slave side.
interface lifo_drain_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/lifo_drain.sv
// Pops up to len entries from an upstream LIFO and streams them out, absorbing the
// LIFO's one-cycle pop-to-data latency with a 2-entry buffer.
//   state   | meaning
//   IDLE    | waiting for start
//   DRAIN   | issuing pops while entries remain and the LIFO is non-empty
//   FLUSH   | no more pops; waiting for in-flight and buffered items to leave
//   DONE    | one-cycle completion pulse
module lifo_drain #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_lifo_empty,
    output logic             o_lifo_pop,
    input  logic [WIDTH-1:0] i_lifo_data,
    lifo_drain_if.master     m_if,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_underrun,
    output logic [CNT_W-1:0] o_popped
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_popped;
    logic             r_underrun;
    logic             r_inflight;
    logic             r_inflight_last;
    logic [WIDTH:0]   r_buf [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;

    logic             w_xfer;
    logic [2:0]       w_level;
    logic [WIDTH:0]   w_head;
    logic             w_pop;
    logic             w_busy;
    logic             w_done;

    assign w_head     = r_buf[r_rd_ptr];
    assign m_if.valid = (r_occ != 2'd0);
    assign m_if.data  = w_head[WIDTH-1:0];
    assign m_if.last  = m_if.valid && w_head[WIDTH];
    assign w_xfer     = m_if.valid && m_if.ready;
    // Projected buffer fill after this edge if no new pop is issued.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len == '0) ? S_FLUSH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_remaining == '0 || i_lifo_empty) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!r_inflight && r_occ == 2'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            S_DRAIN: begin
                w_busy = 1'b1;
                w_pop  = i_reset && !i_lifo_empty && (r_remaining != '0) && (w_level < 3'd2);
            end
            S_FLUSH: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_remaining     <= '0;
            r_popped        <= '0;
            r_underrun      <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf[0]        <= '0;
            r_buf[1]        <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_occ           <= 2'd0;
        end else begin
            r_inflight      <= w_pop;
            r_inflight_last <= w_pop && (r_remaining == CNT_W'(1));

            if (r_state == S_IDLE && i_start) begin
                r_remaining <= i_len;
                r_popped    <= '0;
                r_underrun  <= 1'b0;
            end else if (w_pop) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_popped    <= r_popped + CNT_W'(1);
            end

            if (r_state == S_DRAIN && r_remaining != '0 && i_lifo_empty) begin
                r_underrun <= 1'b1;
            end

            if (r_inflight) begin
                r_buf[r_wr_ptr] <= {r_inflight_last, i_lifo_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end

            if (w_xfer) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({r_inflight, w_xfer})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_lifo_pop = w_pop;
    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_underrun = r_underrun;
    assign o_popped   = r_popped;

endmodule

// File: tb/tb_lifo_drain.sv
// Directed bench for lifo_drain: a behavioural LIFO feeds the DUT, a negedge monitor
// logs transfers and pops, and every expectation is a hand-computed constant.
module tb_lifo_drain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       lifo_empty;
    logic       lifo_pop;
    logic [7:0] lifo_data;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [3:0] popped;

    always #5 clk = ~clk;

    lifo_drain_if #(.WIDTH(8)) s_if ();

    lifo_drain #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_len        (len),
        .i_lifo_empty (lifo_empty),
        .o_lifo_pop   (lifo_pop),
        .i_lifo_data  (lifo_data),
        .m_if         (s_if),
        .o_busy       (busy),
        .o_done       (done),
        .o_underrun   (underrun),
        .o_popped     (popped)
    );

    // Behavioural LIFO: data_out valid the cycle after a sampled pop.
    logic [7:0] stk  [0:15];
    logic [7:0] ld_v [0:15];
    logic [3:0] top = 4'd0;
    logic [3:0] ld_n;
    logic       ld_en;

    assign lifo_empty = (top == 4'd0);

    always @(posedge clk) begin
        if (ld_en) begin
            top <= ld_n;
            for (int i = 0; i < 16; i++) stk[i] <= ld_v[i];
        end else if (lifo_pop && top != 4'd0) begin
            lifo_data <= stk[top - 4'd1];
            top       <= top - 4'd1;
        end
    end

    int         cyc     = 0;
    int         n_xfer  = 0;
    int         n_pop   = 0;
    int         n_bad   = 0;
    int         n_done  = 0;
    int         n_valid = 0;
    logic [7:0] xd [0:63];
    logic       xl [0:63];
    int         xc [0:63];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (s_if.valid && s_if.ready) begin
            xd[n_xfer[5:0]] <= s_if.data;
            xl[n_xfer[5:0]] <= s_if.last;
            xc[n_xfer[5:0]] <= cyc;
            n_xfer          <= n_xfer + 1;
        end
        if (lifo_pop)               n_pop   <= n_pop + 1;
        if (lifo_pop && lifo_empty) n_bad   <= n_bad + 1;
        if (done)                   n_done  <= n_done + 1;
        if (s_if.valid)             n_valid <= n_valid + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [3:0] n);
        ld_v[0] = a;
        ld_v[1] = b;
        ld_v[2] = c;
        ld_n    = n;
        @(posedge clk); #1 ld_en = 1'b1;
        @(posedge clk); #1 ld_en = 1'b0;
    endtask

    task automatic kick(input logic [3:0] l);
        @(posedge clk); #1 start = 1'b1; len = l;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int         b;
    int         p;
    int         d;
    int         v;
    int         viol;
    logic       seen;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        ld_en     = 1'b0;
        s_if.ready = 1'b0;
        for (int i = 0; i < 16; i++) ld_v[i] = 8'h00;

        // Reset held while the LIFO is non-empty
        load(8'h11, 8'h22, 8'h33, 4'd3);
        @(negedge clk);
        chk("rst_lifo_pop", lifo_pop, 0);
        chk("rst_m_valid", s_if.valid, 0);
        chk("rst_m_last", s_if.last, 0);
        chk("rst_m_data", s_if.data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_popped", popped, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full drain, consumer always ready
        s_if.ready = 1'b1;
        b = n_xfer; p = n_pop; d = n_done;
        kick(4'd3);
        wait_done("full_done_seen");
        chk("full_popped", popped, 3);
        chk("full_underrun", underrun, 0);
        @(negedge clk);
        chk("full_busy_after", busy, 0);
        chk("full_count", n_xfer - b, 3);
        chk("full_d0", xd[b], 8'h33);
        chk("full_d1", xd[b+1], 8'h22);
        chk("full_d2", xd[b+2], 8'h11);
        chk("full_last", {xl[b], xl[b+1], xl[b+2]}, 3'b001);
        chk("full_back_to_back", xc[b+2] - xc[b], 2);
        chk("full_done_pulses", n_done - d, 1);
        chk("full_pops", n_pop - p, 3);

        // Back-pressure: consumer stalled for 5 cycles
        load(8'h11, 8'h22, 8'h33, 4'd3);
        s_if.ready = 1'b0;
        b = n_xfer; p = n_pop; viol = 0;
        kick(4'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (s_if.valid && s_if.data != 8'h33) viol++;
        end
        chk("bp_pops_before_xfer", n_pop - p, 2);
        chk("bp_valid", s_if.valid, 1);
        chk("bp_head_data", s_if.data, 8'h33);
        chk("bp_head_stable", viol, 0);
        @(posedge clk); #1 s_if.ready = 1'b1;
        wait_done("bp_done_seen");
        @(negedge clk);
        chk("bp_count", n_xfer - b, 3);
        chk("bp_data", {xd[b], xd[b+1], xd[b+2]}, 24'h332211);
        chk("bp_last", {xl[b], xl[b+1], xl[b+2]}, 3'b001);

        // Underrun: only two entries for a request of four
        load(8'h11, 8'h22, 8'h00, 4'd2);
        b = n_xfer; p = n_pop; d = n_done;
        kick(4'd4);
        wait_done("ur_done_seen");
        chk("ur_popped", popped, 2);
        chk("ur_underrun", underrun, 1);
        @(negedge clk);
        chk("ur_count", n_xfer - b, 2);
        chk("ur_data", {xd[b], xd[b+1]}, 16'h2211);
        chk("ur_no_last", {xl[b], xl[b+1]}, 2'b00);
        chk("ur_done_pulses", n_done - d, 1);
        chk("ur_no_pop_when_empty", n_bad, 0);

        // Zero-length request
        load(8'h44, 8'h00, 8'h00, 4'd1);
        p = n_pop; v = n_valid;
        kick(4'd0);
        wait_done("zero_done_seen");
        @(negedge clk);
        chk("zero_pops", n_pop - p, 0);
        chk("zero_valid", n_valid - v, 0);
        chk("zero_popped", popped, 0);
        chk("zero_underrun_cleared", underrun, 0);

        // Start pulsed while busy is ignored
        load(8'h11, 8'h22, 8'h33, 4'd3);
        b = n_xfer; p = n_pop; d = n_done;
        kick(4'd2);
        @(posedge clk); #1 start = 1'b1; len = 4'd7;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ign_done_seen");
        chk("ign_popped", popped, 2);
        repeat (5) @(negedge clk);
        chk("ign_pops", n_pop - p, 2);
        chk("ign_count", n_xfer - b, 2);
        chk("ign_data", {xd[b], xd[b+1]}, 16'h3322);
        chk("ign_last", {xl[b], xl[b+1]}, 2'b01);
        chk("ign_done_pulses", n_done - d, 1);
        chk("ign_busy_after", busy, 0);

        // Reset one cycle after first valid, then drain what is left
        load(8'h11, 8'h22, 8'h33, 4'd3);
        s_if.ready = 1'b0;
        kick(4'd3);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_if.valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rmd_valid_seen", seen, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rmd_valid", s_if.valid, 0);
        chk("rmd_busy", busy, 0);
        chk("rmd_pop", lifo_pop, 0);
        chk("rmd_popped", popped, 0);
        s_if.ready = 1'b1;
        b = n_xfer;
        kick(4'd3);
        wait_done("rmd_done_seen");
        chk("rmd_popped_after", popped, 1);
        chk("rmd_underrun_after", underrun, 1);
        @(negedge clk);
        chk("rmd_count", n_xfer - b, 1);
        chk("rmd_data", xd[b], 8'h11);
        chk("rmd_last", xl[b], 0);
        chk("no_pop_when_empty", n_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
